// File: rtl/ibex_instr_mem_responder_pkg.sv
// Shared types and parameter legality helper for the instruction-memory responder.
package ibex_imem_pkg;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } imem_resp_t;

    localparam int unsigned MaxRespLatency     = 4;
    localparam int unsigned MaxOutstandingCap  = 4;

    function automatic bit imem_params_legal(input int unsigned resp_latency,
                                             input int unsigned max_outstanding);
        return (resp_latency >= 1) && (resp_latency <= MaxRespLatency) &&
               (max_outstanding >= 1) && (max_outstanding <= MaxOutstandingCap);
    endfunction

endpackage

// File: rtl/ibex_instr_mem_responder_if.sv
// Instruction fetch bus between the prefetch buffer (master) and the memory responder (slave).
interface ibex_instr_mem_responder_if;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;

    modport master (
        output instr_req_i, instr_addr_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o
    );

    modport slave (
        input  instr_req_i, instr_addr_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o
    );
endinterface

// File: rtl/ibex_instr_mem_responder_delay.sv
// Fixed-depth response pipeline; the last stage is the registered bus response.
module ibex_imem_delay_line
    import ibex_imem_pkg::*;
#(
    parameter int unsigned Depth = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  imem_resp_t in_i,
    output imem_resp_t out_o
);

    imem_resp_t stages_q [Depth];
    imem_resp_t stages_d [Depth];

    always_comb begin
        stages_d[0] = in_i;
        for (int i = 1; i < int'(Depth); i++) begin
            stages_d[i] = stages_q[i-1];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                stages_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(Depth); i++) begin
                stages_q[i] <= stages_d[i];
            end
        end
    end

    assign out_o = stages_q[Depth-1];

endmodule

// File: rtl/ibex_instr_mem_responder.sv
// Memory-side responder for ibex_prefetch_buffer: stalled grants, fixed-latency in-order responses.
module ibex_instr_mem_responder
    import ibex_imem_pkg::*;
#(
    parameter int unsigned MemDepthWords  = 1024,
    parameter int unsigned RespLatency    = 1,
    parameter int unsigned MaxOutstanding = 2,
    parameter logic [3:0]  GntStallMask   = 4'b0000,
    parameter logic [31:0] ErrBase        = 32'hFFFF_FFFF,
    parameter logic [31:0] ErrLimit       = 32'h0
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    ibex_instr_mem_responder_if.slave    bus,
    input  logic                         load_we_i,
    input  logic [31:0]                  load_addr_i,
    input  logic [31:0]                  load_wdata_i,
    output logic [2:0]                   outstanding_o
);

    localparam int unsigned IdxW   = (MemDepthWords > 1) ? $clog2(MemDepthWords) : 1;
    localparam logic [2:0]  MaxOut = 3'(MaxOutstanding);

    if (!imem_params_legal(RespLatency, MaxOutstanding)) begin : g_param_check
        $error("ibex_instr_mem_responder: RespLatency and MaxOutstanding must be in 1..4");
    end

    logic [1:0]      phase_q, phase_d;
    logic [2:0]      outstanding_q, outstanding_d;
    logic [31:0]     mem_q [MemDepthWords];

    logic [29:0]     rd_word, ld_word;
    logic [IdxW-1:0] rd_idx, ld_idx;
    logic            rd_in_range, ld_in_range, in_err_window, rd_err, gnt;
    logic            unused_load_lsbs;
    imem_resp_t      resp_in, resp_out;

    always_comb begin
        rd_word       = bus.instr_addr_i[31:2];
        ld_word       = load_addr_i[31:2];
        rd_idx        = rd_word[IdxW-1:0];
        ld_idx        = ld_word[IdxW-1:0];
        rd_in_range   = {2'b00, rd_word} < 32'(MemDepthWords);
        ld_in_range   = {2'b00, ld_word} < 32'(MemDepthWords);
        // An empty window (ErrBase > ErrLimit) can never match.
        in_err_window = (ErrBase <= ErrLimit) &&
                        (bus.instr_addr_i >= ErrBase) && (bus.instr_addr_i <= ErrLimit);
        rd_err        = in_err_window || !rd_in_range;

        gnt = rst_ni && bus.instr_req_i && (outstanding_q < MaxOut) && !GntStallMask[phase_q];

        resp_in.valid = gnt;
        resp_in.err   = gnt && rd_err;
        resp_in.rdata = (gnt && !rd_err) ? mem_q[rd_idx] : 32'h0;

        phase_d       = phase_q + 2'd1;
        outstanding_d = outstanding_q;
        case ({gnt, resp_out.valid})
            2'b10:   outstanding_d = outstanding_q + 3'd1;
            2'b01:   outstanding_d = outstanding_q - 3'd1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            phase_q       <= 2'd0;
            outstanding_q <= 3'd0;
        end else begin
            phase_q       <= phase_d;
            outstanding_q <= outstanding_d;
        end
    end

    // NOTE: the program array has no reset so it maps onto plain RAM and survives a core reset.
    always_ff @(posedge clk_i) begin
        if (load_we_i && ld_in_range) begin
            mem_q[ld_idx] <= load_wdata_i;
        end
    end

    ibex_imem_delay_line #(
        .Depth (RespLatency)
    ) u_delay_line (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .in_i   (resp_in),
        .out_o  (resp_out)
    );

    assign unused_load_lsbs   = ^load_addr_i[1:0];

    assign bus.instr_gnt_o    = gnt;
    assign bus.instr_rvalid_o = resp_out.valid;
    assign bus.instr_err_o    = resp_out.err;
    assign bus.instr_rdata_o  = resp_out.rdata;
    assign outstanding_o      = outstanding_q;

endmodule

// File: tb/tb_ibex_instr_mem_responder.sv
// Directed bench: four responder instances with different latency/limit/stall settings on one clock.
module tb_ibex_instr_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_we;
    logic [31:0] load_addr;
    logic [31:0] load_wdata;
    logic [2:0]  out_a, out_b, out_c, out_d;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ibex_instr_mem_responder_if bus_a ();
    ibex_instr_mem_responder_if bus_b ();
    ibex_instr_mem_responder_if bus_c ();
    ibex_instr_mem_responder_if bus_d ();

    ibex_instr_mem_responder #(
        .RespLatency(2), .MaxOutstanding(2), .ErrBase(32'h0000_1000), .ErrLimit(32'h0000_1FFF)
    ) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus_a.slave), .load_we_i(load_we),
        .load_addr_i(load_addr), .load_wdata_i(load_wdata), .outstanding_o(out_a)
    );

    ibex_instr_mem_responder #(.RespLatency(1), .MaxOutstanding(2)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus_b.slave), .load_we_i(load_we),
        .load_addr_i(load_addr), .load_wdata_i(load_wdata), .outstanding_o(out_b)
    );

    ibex_instr_mem_responder #(.RespLatency(4), .MaxOutstanding(2)) dut_c (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus_c.slave), .load_we_i(load_we),
        .load_addr_i(load_addr), .load_wdata_i(load_wdata), .outstanding_o(out_c)
    );

    ibex_instr_mem_responder #(
        .RespLatency(1), .MaxOutstanding(2), .GntStallMask(4'b0101)
    ) dut_d (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus_d.slave), .load_we_i(load_we),
        .load_addr_i(load_addr), .load_wdata_i(load_wdata), .outstanding_o(out_d)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One isolated fetch on instance A (latency 2), optionally with a same-cycle load to that word.
    task automatic fetch_a(input string tag, input logic [31:0] addr, input logic exp_err,
                           input logic [31:0] exp_data, input logic do_load,
                           input logic [31:0] ld_data);
        bus_a.instr_req_i  = 1'b1;
        bus_a.instr_addr_i = addr;
        if (do_load) begin
            load_we    = 1'b1;
            load_addr  = addr;
            load_wdata = ld_data;
        end
        @(negedge clk);
        check({tag, "/gnt"}, 32'(bus_a.instr_gnt_o), 32'd1);
        next_cycle();
        bus_a.instr_req_i = 1'b0;
        load_we           = 1'b0;
        @(negedge clk);
        check({tag, "/early_rvalid"}, 32'(bus_a.instr_rvalid_o), 32'd0);
        check({tag, "/outst1"}, 32'(out_a), 32'd1);
        next_cycle();
        @(negedge clk);
        check({tag, "/rvalid"}, 32'(bus_a.instr_rvalid_o), 32'd1);
        check({tag, "/err"}, 32'(bus_a.instr_err_o), 32'(exp_err));
        check({tag, "/rdata"}, bus_a.instr_rdata_o, exp_data);
        next_cycle();
        @(negedge clk);
        check({tag, "/rvalid_drop"}, 32'(bus_a.instr_rvalid_o), 32'd0);
        check({tag, "/outst0"}, 32'(out_a), 32'd0);
        next_cycle();
    endtask

    initial begin
        rst_n = 1'b0;
        load_we = 1'b0; load_addr = '0; load_wdata = '0;
        bus_a.instr_req_i = 1'b0; bus_a.instr_addr_i = '0;
        bus_b.instr_req_i = 1'b0; bus_b.instr_addr_i = '0;
        bus_c.instr_req_i = 1'b0; bus_c.instr_addr_i = '0;
        bus_d.instr_req_i = 1'b0; bus_d.instr_addr_i = '0;
        next_cycle();

        // Preload while in reset: the array is not affected by reset.
        load_we = 1'b1;
        load_addr = 32'h0;  load_wdata = 32'h1111_1111; next_cycle();
        load_addr = 32'h4;  load_wdata = 32'h2222_2222; next_cycle();
        load_addr = 32'h8;  load_wdata = 32'h3333_3333; next_cycle();
        load_addr = 32'h40; load_wdata = 32'hDEAD_BEEF; next_cycle();
        load_we = 1'b0;

        bus_a.instr_req_i = 1'b1; bus_a.instr_addr_i = 32'h40;
        @(negedge clk);
        check("rst/gnt", 32'(bus_a.instr_gnt_o), 32'd0);
        check("rst/rvalid", 32'(bus_a.instr_rvalid_o), 32'd0);
        check("rst/err", 32'(bus_a.instr_err_o), 32'd0);
        check("rst/rdata", bus_a.instr_rdata_o, 32'd0);
        check("rst/outst", 32'(out_a), 32'd0);
        next_cycle();
        bus_a.instr_req_i = 1'b0;
        rst_n = 1'b1;

        // Stall mask 0101: phase 0 first after reset, grants only in odd phases.
        bus_d.instr_req_i = 1'b1; bus_d.instr_addr_i = 32'h0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("stall/gnt%0d", i), 32'(bus_d.instr_gnt_o), 32'(i % 2));
            next_cycle();
        end
        bus_d.instr_req_i = 1'b0;
        next_cycle();
        next_cycle();

        fetch_a("fetch40", 32'h40, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0);
        fetch_a("err1004", 32'h1004, 1'b1, 32'h0, 1'b0, 32'h0);
        fetch_a("err_idx1024", 32'h1000, 1'b1, 32'h0, 1'b0, 32'h0);
        fetch_a("err_1ffc", 32'h1FFC, 1'b1, 32'h0, 1'b0, 32'h0);
        fetch_a("err_depth", 32'h2000, 1'b1, 32'h0, 1'b0, 32'h0);
        fetch_a("rd_old", 32'h40, 1'b0, 32'hDEAD_BEEF, 1'b1, 32'hCAFE_F00D);
        fetch_a("rd_new", 32'h40, 1'b0, 32'hCAFE_F00D, 1'b0, 32'h0);

        // Streaming, latency 1: one grant and one response per cycle.
        bus_b.instr_req_i = 1'b1; bus_b.instr_addr_i = 32'h0;
        @(negedge clk);
        check("stream/gnt0", 32'(bus_b.instr_gnt_o), 32'd1);
        check("stream/rv0", 32'(bus_b.instr_rvalid_o), 32'd0);
        next_cycle();
        bus_b.instr_addr_i = 32'h4;
        @(negedge clk);
        check("stream/gnt1", 32'(bus_b.instr_gnt_o), 32'd1);
        check("stream/data1", bus_b.instr_rdata_o, 32'h1111_1111);
        check("stream/outst1", 32'(out_b), 32'd1);
        next_cycle();
        bus_b.instr_addr_i = 32'h8;
        @(negedge clk);
        check("stream/gnt2", 32'(bus_b.instr_gnt_o), 32'd1);
        check("stream/data2", bus_b.instr_rdata_o, 32'h2222_2222);
        check("stream/outst2", 32'(out_b), 32'd1);
        next_cycle();
        bus_b.instr_req_i = 1'b0;
        @(negedge clk);
        check("stream/rv3", 32'(bus_b.instr_rvalid_o), 32'd1);
        check("stream/data3", bus_b.instr_rdata_o, 32'h3333_3333);
        next_cycle();
        @(negedge clk);
        check("stream/rv4", 32'(bus_b.instr_rvalid_o), 32'd0);
        check("stream/outst4", 32'(out_b), 32'd0);
        next_cycle();

        // Full block, latency 4, limit 2.
        bus_c.instr_req_i = 1'b1; bus_c.instr_addr_i = 32'h0;
        @(negedge clk); check("full/gnt0", 32'(bus_c.instr_gnt_o), 32'd1);
        next_cycle();
        bus_c.instr_addr_i = 32'h4;
        @(negedge clk); check("full/gnt1", 32'(bus_c.instr_gnt_o), 32'd1);
        next_cycle();
        bus_c.instr_addr_i = 32'h8;
        @(negedge clk);
        check("full/gnt2", 32'(bus_c.instr_gnt_o), 32'd0);
        check("full/outst2", 32'(out_c), 32'd2);
        next_cycle();
        @(negedge clk); check("full/gnt3", 32'(bus_c.instr_gnt_o), 32'd0);
        next_cycle();
        @(negedge clk);
        check("full/rv4", 32'(bus_c.instr_rvalid_o), 32'd1);
        check("full/data4", bus_c.instr_rdata_o, 32'h1111_1111);
        check("full/gnt4_no_bypass", 32'(bus_c.instr_gnt_o), 32'd0);
        check("full/outst4", 32'(out_c), 32'd2);
        next_cycle();
        @(negedge clk);
        check("full/gnt5", 32'(bus_c.instr_gnt_o), 32'd1);
        check("full/outst5", 32'(out_c), 32'd1);
        check("full/data5", bus_c.instr_rdata_o, 32'h2222_2222);
        next_cycle();
        bus_c.instr_req_i = 1'b0;
        @(negedge clk);
        check("full/rv6", 32'(bus_c.instr_rvalid_o), 32'd0);
        check("full/outst6", 32'(out_c), 32'd1);
        next_cycle(); next_cycle(); next_cycle();
        @(negedge clk);
        check("full/rv9", 32'(bus_c.instr_rvalid_o), 32'd1);
        check("full/data9", bus_c.instr_rdata_o, 32'h3333_3333);
        next_cycle();
        @(negedge clk);
        check("full/outst10", 32'(out_c), 32'd0);
        next_cycle();

        // Reset with two requests in flight on A.
        bus_a.instr_req_i = 1'b1; bus_a.instr_addr_i = 32'h0;
        @(negedge clk); check("rstmid/gnt0", 32'(bus_a.instr_gnt_o), 32'd1);
        next_cycle();
        bus_a.instr_addr_i = 32'h4;
        @(negedge clk); check("rstmid/gnt1", 32'(bus_a.instr_gnt_o), 32'd1);
        next_cycle();
        rst_n = 1'b0;
        bus_a.instr_addr_i = 32'h8;
        @(negedge clk);
        check("rstmid/outst2", 32'(out_a), 32'd2);
        check("rstmid/gnt_in_rst", 32'(bus_a.instr_gnt_o), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        bus_a.instr_req_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("rstmid/rv%0d", i), 32'(bus_a.instr_rvalid_o), 32'd0);
            check($sformatf("rstmid/outst%0d", i), 32'(out_a), 32'd0);
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
